block_downsampler: RTL and testbench
====================================

BLOCK_DOWNSAMPLER -- requirements
Module: block_downsampler

Interface
REQ-001 SHALL have parameter PIX_W, default 16: pixel width in bits.
REQ-002 SHALL have parameter BLK, default 8: block edge in pixels; power of two, 4..16.
REQ-003 SHALL have parameter SCALE, default 2: reduction factor per axis; 2 or 4, SCALE < BLK.
REQ-004 SHALL have port Clock  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port Input_Reset_N  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port Input_Pixel  input  PIX_W: raster-order pixel of the block being filled.
REQ-007 SHALL have port Input_Valid  input  1: Input_Pixel valid this cycle.
REQ-008 SHALL have port Input_Ready  output  1: block can accept a pixel this cycle.
REQ-009 SHALL have port Mode  input  2: 00 average, 01 decimate (top-left), 10 max, 11 min.
REQ-010 SHALL have port Output_Pixel  output  PIX_W: reduced pixel.
REQ-011 SHALL have port Output_Valid  output  1: Output_Pixel valid.
REQ-012 SHALL have port Output_Ready  input  1: downstream accepts Output_Pixel.
REQ-013 SHALL have port Output_Last  output  1: high with the final reduced pixel of a block.
REQ-014 SHALL have port Output_Finish  output  1: one-cycle pulse after a block is fully drained.

Function
REQ-015 SHALL transfer a pixel only on a cycle where Input_Valid and Input_Ready are both high; same rule for Output_Valid/Output_Ready.
REQ-016 SHALL store pixels in two BLK*BLK banks (ping-pong): one filled by input, one drained by output.
REQ-017 SHALL swap banks on the edge accepting pixel BLK*BLK-1 when the read bank is empty, or on the edge draining the read bank's last pixel, whichever is later.
REQ-018 SHALL deassert Input_Ready while the write bank is full and the read bank is not yet drained (input FSM: FILL -> WAIT_SWAP -> FILL).
REQ-019 SHALL latch Mode at bank swap; Mode changes mid-block SHALL not affect that block.
REQ-020 SHALL emit (BLK/SCALE)^2 pixels per block in raster order; output k covers rows SCALE*(k/(BLK/SCALE))+0..SCALE-1 and matching columns.
REQ-021 SHALL compute average as the full-precision sum (PIX_W+2*log2(SCALE) bits) shifted right by 2*log2(SCALE), truncating; no overflow for any input.
REQ-022 SHALL assert Output_Valid on the second rising edge after the swap edge (output FSM: IDLE -> STREAM -> IDLE).
REQ-023 SHALL hold Output_Pixel, Output_Valid and Output_Last stable while Output_Valid=1 and Output_Ready=0.
REQ-024 SHALL sustain one output per cycle with Output_Ready high and no bubble between consecutive blocks when the next bank is already full.
REQ-025 SHALL pulse Output_Finish for exactly one cycle, on the edge after the Output_Last handshake.

Reset
REQ-026 SHALL, on Input_Reset_N low, immediately clear Output_Pixel, Output_Valid, Output_Last, Output_Finish to 0, Input_Ready to 0, counters to 0 and both FSMs to FILL/IDLE.
REQ-027 SHALL drive Input_Ready to 1 on the first edge after reset release.
REQ-028 SHALL discard any partial block on reset; bank storage need not be cleared.

Structure
REQ-029 SHALL place the Mode encodings and a clog2-based width function in shared package block_downsampler_pkg.
REQ-030 SHALL implement the SCALE x SCALE reduction as combinational sub-module ds_window_reduce (inputs: window pixels, mode; output: PIX_W result).

Verification (BLK=8, SCALE=2 unless stated)
REQ-031 SHALL cover: ramp pixel i=i, Mode=00, Output_Ready=1 -> 16 outputs 4,6,8,10,20,22,...; Output_Last on 16th; Output_Finish next cycle.
REQ-032 SHALL cover: all pixels 16'hFFFF, Mode=00 -> every output 16'hFFFF.
REQ-033 SHALL cover: ramp with Mode=10 -> first output 9; Mode=01 -> 0; Mode=11 -> 0; Mode toggled mid-block -> no effect.
REQ-034 SHALL cover: three back-to-back blocks, Output_Ready=0 -> Input_Ready low after 128 accepted pixels; raising Output_Ready drains 16 outputs, swaps, resumes input.
REQ-035 SHALL cover: reset after 30 input pixels and during output streaming -> all outputs 0 at once; next 64 pixels form a fresh block.
REQ-036 SHALL cover: SCALE=4 build, ramp, Mode=00 -> 4 outputs, first 13, Output_Last on 4th.

Source files
------------

// File: rtl/block_downsampler_pkg.sv
// block_downsampler_pkg
//   Shared definitions for the block downsampler:
//   - mode_e      : reduction mode encodings driven on the Mode port
//   - in_state_e  : input-side FSM states (filling the write bank / waiting for a swap)
//   - out_state_e : output-side FSM states (idle / streaming the read bank)
//   - clog2_width : bit width needed to index 'value' items, never less than 1
package block_downsampler_pkg;

  typedef enum logic [1:0] {
    MODE_AVG      = 2'b00,
    MODE_DECIMATE = 2'b01,
    MODE_MAX      = 2'b10,
    MODE_MIN      = 2'b11
  } mode_e;

  typedef enum logic {
    IN_FILL      = 1'b0,
    IN_WAIT_SWAP = 1'b1
  } in_state_e;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_STREAM = 1'b1
  } out_state_e;

  function automatic int clog2_width(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/ds_window_reduce.sv
// ds_window_reduce
//   Combinational reduction of one SCALE x SCALE window to a single pixel.
//   Ports:
//     window_pixels : SCALE*SCALE pixels, window pixel (r,c) at slice r*SCALE+c
//     mode          : mode_e encoding (average / top-left / max / min)
//     result        : reduced PIX_W pixel
module ds_window_reduce
  import block_downsampler_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int SCALE = 2
) (
  input  logic [SCALE*SCALE*PIX_W-1:0] window_pixels,
  input  logic [1:0]                   mode,
  output logic [PIX_W-1:0]             result
);

  localparam int LS    = clog2_width(SCALE);
  localparam int NPIX  = SCALE * SCALE;
  // Sum is wide enough that SCALE*SCALE full-scale pixels never overflow.
  localparam int SUM_W = PIX_W + 2 * LS;

  logic [SUM_W-1:0] sum;
  logic [PIX_W-1:0] max_v;
  logic [PIX_W-1:0] min_v;
  logic [PIX_W-1:0] pix;
  logic             unused_sum_lsbs;

  always_comb begin
    sum   = '0;
    max_v = '0;
    min_v = '1;
    pix   = '0;
    for (int i = 0; i < NPIX; i++) begin
      pix = window_pixels[i*PIX_W +: PIX_W];
      sum = sum + SUM_W'(pix);
      if (pix > max_v) max_v = pix;
      if (pix < min_v) min_v = pix;
    end
  end

  // The dropped fraction bits are the truncation of the average.
  assign unused_sum_lsbs = ^sum[2*LS-1:0];

  always_comb begin
    case (mode)
      MODE_AVG:      result = sum[SUM_W-1:2*LS];
      MODE_DECIMATE: result = window_pixels[PIX_W-1:0];
      MODE_MAX:      result = max_v;
      default:       result = min_v;
    endcase
  end

endmodule

// File: rtl/block_downsampler.sv
// block_downsampler
//   Ping-pong buffered BLK x BLK block downsampler. One bank is filled in raster
//   order from the input stream while the other is reduced SCALE x SCALE at a time
//   and streamed out in raster order.
//   Ports:
//     Clock, Input_Reset_N        : clock (rising edge), async active-low reset
//     Input_Pixel/Valid/Ready     : raster pixel stream into the write bank
//     Mode                        : reduction mode, sampled when banks swap
//     Output_Pixel/Valid/Ready    : reduced pixel stream
//     Output_Last                 : marks the final reduced pixel of a block
//     Output_Finish               : one-cycle pulse after the last pixel is taken
module block_downsampler
  import block_downsampler_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int BLK   = 8,
  parameter int SCALE = 2
) (
  input  logic             Clock,
  input  logic             Input_Reset_N,
  input  logic [PIX_W-1:0] Input_Pixel,
  input  logic             Input_Valid,
  output logic             Input_Ready,
  input  logic [1:0]       Mode,
  output logic [PIX_W-1:0] Output_Pixel,
  output logic             Output_Valid,
  input  logic             Output_Ready,
  output logic             Output_Last,
  output logic             Output_Finish
);

  localparam int LB     = clog2_width(BLK);
  localparam int LS     = clog2_width(SCALE);
  localparam int LW     = LB - LS;
  localparam int NPIX   = BLK * BLK;
  localparam int NWIN   = (BLK / SCALE) * (BLK / SCALE);
  localparam int ADDR_W = 2 * LB + 1;

  in_state_e             in_state;
  out_state_e            out_state;
  logic                  bank_sel;
  logic [2*LB-1:0]       wr_cnt;
  logic [2*LW-1:0]       rd_idx;
  logic [1:0]            rd_mode;

  logic [PIX_W-1:0]      mem [2**ADDR_W];
  logic [SCALE*SCALE*PIX_W-1:0] window_pixels;
  logic [PIX_W-1:0]      reduced;

  logic                  s1_valid;
  logic                  s1_last;
  logic [PIX_W-1:0]      s1_pixel;

  logic                  in_fire;
  logic                  wr_last;
  logic                  advance;
  logic                  rd_fire;
  logic                  rd_last_fire;
  logic                  rd_free;
  logic                  swap;

  assign in_fire      = Input_Valid && Input_Ready;
  assign wr_last      = in_fire && (wr_cnt == (2*LB)'(NPIX - 1));
  // Both pipeline stages move together whenever the output register can take data.
  assign advance      = !Output_Valid || Output_Ready;
  assign rd_fire      = (out_state == OUT_STREAM) && advance;
  assign rd_last_fire = rd_fire && (rd_idx == (2*LW)'(NWIN - 1));
  // The read bank is free once its last window has been pulled into the pipeline;
  // the pipeline registers hold the in-flight data, so the bank can be refilled.
  assign rd_free      = (out_state == OUT_IDLE) || rd_last_fire;
  assign swap         = rd_free && (wr_last || (in_state == IN_WAIT_SWAP));

  // Input FSM: owns the write counter, bank select and Input_Ready.
  always_ff @(posedge Clock or negedge Input_Reset_N) begin
    if (!Input_Reset_N) begin
      in_state    <= IN_FILL;
      Input_Ready <= 1'b0;
      wr_cnt      <= '0;
      bank_sel    <= 1'b0;
    end else begin
      if (swap) bank_sel <= !bank_sel;
      case (in_state)
        IN_FILL: begin
          Input_Ready <= 1'b1;
          if (in_fire) wr_cnt <= wr_cnt + 1'b1;
          if (wr_last && !swap) begin
            in_state    <= IN_WAIT_SWAP;
            Input_Ready <= 1'b0;
          end
        end
        IN_WAIT_SWAP: begin
          if (swap) begin
            in_state    <= IN_FILL;
            Input_Ready <= 1'b1;
          end
        end
        default: in_state <= IN_FILL;
      endcase
    end
  end

  // Bank storage is not reset; stale contents are never read before a full refill.
  always_ff @(posedge Clock) begin
    if (in_fire) mem[{bank_sel, wr_cnt}] <= Input_Pixel;
  end

  // Gather the current window of the read bank. rd_idx splits into window row
  // (upper LW bits) and window column (lower LW bits).
  for (genvar gr = 0; gr < SCALE; gr++) begin : g_row
    for (genvar gc = 0; gc < SCALE; gc++) begin : g_col
      localparam logic [LS-1:0] ROW_OFS = LS'(gr);
      localparam logic [LS-1:0] COL_OFS = LS'(gc);
      assign window_pixels[(gr*SCALE+gc)*PIX_W +: PIX_W] =
        mem[{~bank_sel, rd_idx[2*LW-1:LW], ROW_OFS, rd_idx[LW-1:0], COL_OFS}];
    end
  end

  ds_window_reduce #(
    .PIX_W(PIX_W),
    .SCALE(SCALE)
  ) u_reduce (
    .window_pixels(window_pixels),
    .mode         (rd_mode),
    .result       (reduced)
  );

  // Output FSM: walks the windows of the read bank; Mode is captured at the swap.
  always_ff @(posedge Clock or negedge Input_Reset_N) begin
    if (!Input_Reset_N) begin
      out_state <= OUT_IDLE;
      rd_idx    <= '0;
      rd_mode   <= MODE_AVG;
    end else begin
      if (rd_fire) rd_idx <= rd_idx + 1'b1;
      case (out_state)
        OUT_IDLE: begin
          if (swap) begin
            out_state <= OUT_STREAM;
            rd_idx    <= '0;
            rd_mode   <= Mode;
          end
        end
        OUT_STREAM: begin
          if (swap) begin
            rd_idx  <= '0;
            rd_mode <= Mode;
          end else if (rd_last_fire) begin
            out_state <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  // Two-stage output pipeline: reduced window register, then the output register.
  // A stalled output freezes both stages, which keeps the outputs stable.
  always_ff @(posedge Clock or negedge Input_Reset_N) begin
    if (!Input_Reset_N) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_pixel      <= '0;
      Output_Valid  <= 1'b0;
      Output_Last   <= 1'b0;
      Output_Pixel  <= '0;
      Output_Finish <= 1'b0;
    end else begin
      if (advance) begin
        s1_valid     <= rd_fire;
        s1_last      <= rd_last_fire;
        s1_pixel     <= reduced;
        Output_Valid <= s1_valid;
        Output_Last  <= s1_last;
        Output_Pixel <= s1_pixel;
      end
      Output_Finish <= Output_Valid && Output_Ready && Output_Last;
    end
  end

endmodule

// File: tb/tb_block_downsampler.sv
// tb_block_downsampler
//   Scoreboard bench: stimulus pushes hand-derived expected pixels into a queue,
//   negedge monitors pop and compare on every output handshake. A second
//   instance built with SCALE=4 covers the larger window.
module tb_block_downsampler;

  typedef struct packed {
    logic [15:0] pixel;
    logic        last;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Input_Reset_N;
  logic [15:0] Input_Pixel;
  logic        Input_Valid;
  logic        Input_Ready;
  logic [1:0]  Mode;
  logic [15:0] Output_Pixel;
  logic        Output_Valid;
  logic        Output_Ready;
  logic        Output_Last;
  logic        Output_Finish;

  logic [15:0] s4_in_pixel;
  logic        s4_in_valid;
  logic        s4_in_ready;
  logic [1:0]  s4_mode;
  logic [15:0] s4_out_pixel;
  logic        s4_out_valid;
  logic        s4_out_ready;
  logic        s4_out_last;
  logic        s4_out_finish;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  exp_t mon_e;
  exp_t mon4_e;
  exp_t held;
  int   checks   = 0;
  int   failures = 0;
  logic pend_finish  = 1'b0;
  logic hold_pending = 1'b0;
  logic pend4        = 1'b0;

  always #5 Clock = ~Clock;

  block_downsampler #(.PIX_W(16), .BLK(8), .SCALE(2)) dut (
    .Clock        (Clock),
    .Input_Reset_N(Input_Reset_N),
    .Input_Pixel  (Input_Pixel),
    .Input_Valid  (Input_Valid),
    .Input_Ready  (Input_Ready),
    .Mode         (Mode),
    .Output_Pixel (Output_Pixel),
    .Output_Valid (Output_Valid),
    .Output_Ready (Output_Ready),
    .Output_Last  (Output_Last),
    .Output_Finish(Output_Finish)
  );

  block_downsampler #(.PIX_W(16), .BLK(8), .SCALE(4)) dut4 (
    .Clock        (Clock),
    .Input_Reset_N(Input_Reset_N),
    .Input_Pixel  (s4_in_pixel),
    .Input_Valid  (s4_in_valid),
    .Input_Ready  (s4_in_ready),
    .Mode         (s4_mode),
    .Output_Pixel (s4_out_pixel),
    .Output_Valid (s4_out_valid),
    .Output_Ready (s4_out_ready),
    .Output_Last  (s4_out_last),
    .Output_Finish(s4_out_finish)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor for the SCALE=2 instance: scoreboard compare, hold stability, finish pulse.
  always @(negedge Clock) begin
    if (!Input_Reset_N) begin
      pend_finish  = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (pend_finish || Output_Finish) check_output("finish_pulse", Output_Finish, pend_finish);
      if (hold_pending) begin
        check_output("hold_valid", Output_Valid, 1);
        check_output("hold_pixel", Output_Pixel, held.pixel);
        check_output("hold_last", Output_Last, held.last);
      end
      pend_finish  = 1'b0;
      hold_pending = 1'b0;
      if (Output_Valid) begin
        if (Output_Ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output at %0t", Output_Pixel, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check_output("out_pixel", Output_Pixel, mon_e.pixel);
            check_output("out_last", Output_Last, mon_e.last);
            pend_finish = mon_e.last;
          end
        end else begin
          hold_pending = 1'b1;
          held.pixel   = Output_Pixel;
          held.last    = Output_Last;
        end
      end
    end
  end

  // Monitor for the SCALE=4 instance.
  always @(negedge Clock) begin
    if (!Input_Reset_N) begin
      pend4 = 1'b0;
    end else begin
      if (pend4 || s4_out_finish) check_output("s4_finish_pulse", s4_out_finish, pend4);
      pend4 = 1'b0;
      if (s4_out_valid && s4_out_ready) begin
        if (exp4_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL s4_unexpected_output: got 0x%0h, expected no output at %0t", s4_out_pixel, $time);
        end else begin
          mon4_e = exp4_q.pop_front();
          check_output("s4_out_pixel", s4_out_pixel, mon4_e.pixel);
          check_output("s4_out_last", s4_out_last, mon4_e.last);
          pend4 = mon4_e.last;
        end
      end
    end
  end

  // Hand-derived results for an 8x8 ramp (pixel i = base+i) or descending ramp
  // (pixel i = base+63-i) reduced 2x2. p is the raster index of the window's top-left.
  function automatic logic [15:0] ramp_expect(input int base, input bit desc, input logic [1:0] mode_v, input int k);
    int p;
    int v;
    p = 16 * (k / 4) + 2 * (k % 4);
    if (!desc) begin
      case (mode_v)
        2'b00:   v = base + p + 4;
        2'b10:   v = base + p + 9;
        default: v = base + p;
      endcase
    end else begin
      case (mode_v)
        2'b00:   v = base + 58 - p;
        2'b11:   v = base + 54 - p;
        default: v = base + 63 - p;
      endcase
    end
    return 16'(v);
  endfunction

  task automatic send_pixel(input logic [15:0] pix, input logic [1:0] mode_v);
    int waited = 0;
    Input_Pixel = pix;
    Input_Valid = 1'b1;
    Mode        = mode_v;
    @(negedge Clock);
    while (!Input_Ready && waited < 400) begin
      @(negedge Clock);
      waited++;
    end
    if (!Input_Ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL input_accept_timeout: Input_Ready=0, required 1 at %0t", $time);
    end
    @(posedge Clock);
    #1;
    Input_Valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int base, input bit desc, input logic [1:0] mode_v);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.pixel = ramp_expect(base, desc, mode_v, k);
      e.last  = (k == 15);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 64; i++) send_pixel(16'(desc ? base + 63 - i : base + i), mode_v);
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while ((exp_q.size() != 0 || Output_Valid) && waited < 3000) begin
      @(negedge Clock);
      waited++;
    end
    check_output({name, "_drained"}, exp_q.size(), 0);
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    Input_Reset_N = 1'b0;
    #1;
    check_output({name, "_rst_valid"}, Output_Valid, 0);
    check_output({name, "_rst_pixel"}, Output_Pixel, 0);
    check_output({name, "_rst_last"}, Output_Last, 0);
    check_output({name, "_rst_finish"}, Output_Finish, 0);
    check_output({name, "_rst_in_ready"}, Input_Ready, 0);
    exp_q.delete();
    exp4_q.delete();
    Input_Valid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Input_Reset_N = 1'b1;
    check_output({name, "_ready_before_edge"}, Input_Ready, 0);
    @(posedge Clock);
    #1;
    check_output({name, "_ready_after_edge"}, Input_Ready, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    int   waited;
    Input_Reset_N = 1'b0;
    Input_Pixel   = '0;
    Input_Valid   = 1'b0;
    Mode          = 2'b00;
    Output_Ready  = 1'b1;
    s4_in_pixel   = '0;
    s4_in_valid   = 1'b0;
    s4_mode       = 2'b00;
    s4_out_ready  = 1'b1;

    #2;
    do_reset("init");

    $display("[TB] ramp average with swap latency");
    apply_stimulus(0, 1'b0, 2'b00);
    check_output("latency_swap_edge", Output_Valid, 0);
    @(posedge Clock); #1;
    check_output("latency_edge1", Output_Valid, 0);
    @(posedge Clock); #1;
    check_output("latency_edge2", Output_Valid, 1);
    wait_drain("ramp_avg");

    $display("[TB] full-scale average");
    for (int k = 0; k < 16; k++) begin
      e.pixel = 16'hFFFF;
      e.last  = (k == 15);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 64; i++) send_pixel(16'hFFFF, 2'b00);
    wait_drain("full_scale");

    $display("[TB] max, decimate, min on ramp");
    apply_stimulus(0, 1'b0, 2'b10);
    wait_drain("ramp_max");
    apply_stimulus(0, 1'b0, 2'b01);
    wait_drain("ramp_dec");
    apply_stimulus(0, 1'b0, 2'b11);
    wait_drain("ramp_min");

    $display("[TB] descending ramp average and min, back to back");
    apply_stimulus(200, 1'b1, 2'b00);
    apply_stimulus(200, 1'b1, 2'b11);
    wait_drain("desc");

    $display("[TB] mode toggling around the swap");
    for (int k = 0; k < 16; k++) begin
      e.pixel = ramp_expect(300, 1'b0, 2'b10, k);
      e.last  = (k == 15);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 64; i++) send_pixel(16'(300 + i), (i == 63) ? 2'b10 : ((i % 2) ? 2'b11 : 2'b00));
    for (int c = 0; c < 40; c++) begin
      Mode         = (c % 3 == 0) ? 2'b00 : ((c % 3 == 1) ? 2'b01 : 2'b11);
      Output_Ready = (c % 3 != 0);
      @(posedge Clock); #1;
    end
    Output_Ready = 1'b1;
    wait_drain("mode_toggle");

    $display("[TB] three blocks with output backpressure");
    Output_Ready = 1'b0;
    apply_stimulus(0, 1'b0, 2'b00);
    apply_stimulus(100, 1'b0, 2'b00);
    check_output("ready_low_after_128", Input_Ready, 0);
    repeat (5) @(posedge Clock);
    #1;
    check_output("ready_still_low", Input_Ready, 0);
    check_output("stalled_output_valid", Output_Valid, 1);
    Output_Ready = 1'b1;
    apply_stimulus(1000, 1'b0, 2'b00);
    wait_drain("backpressure");

    $display("[TB] reset during a partial block");
    for (int i = 0; i < 30; i++) send_pixel(16'(9000 + i), 2'b10);
    #3;
    do_reset("partial");
    apply_stimulus(500, 1'b0, 2'b00);
    wait_drain("after_partial");

    $display("[TB] reset during output streaming");
    Output_Ready = 1'b0;
    apply_stimulus(700, 1'b0, 2'b00);
    waited = 0;
    while (!Output_Valid && waited < 10) begin
      @(posedge Clock); #1;
      waited++;
    end
    check_output("stream_valid_before_reset", Output_Valid, 1);
    #3;
    do_reset("streaming");
    Output_Ready = 1'b1;
    apply_stimulus(800, 1'b0, 2'b10);
    wait_drain("after_stream_reset");

    $display("[TB] SCALE=4 ramp average");
    e.pixel = 16'd13; e.last = 1'b0; exp4_q.push_back(e);
    e.pixel = 16'd17; e.last = 1'b0; exp4_q.push_back(e);
    e.pixel = 16'd45; e.last = 1'b0; exp4_q.push_back(e);
    e.pixel = 16'd49; e.last = 1'b1; exp4_q.push_back(e);
    for (int i = 0; i < 64; i++) begin
      s4_in_pixel = 16'(i);
      s4_in_valid = 1'b1;
      waited      = 0;
      @(negedge Clock);
      while (!s4_in_ready && waited < 400) begin
        @(negedge Clock);
        waited++;
      end
      @(posedge Clock); #1;
      s4_in_valid = 1'b0;
    end
    waited = 0;
    while ((exp4_q.size() != 0 || s4_out_valid) && waited < 200) begin
      @(negedge Clock);
      waited++;
    end
    check_output("s4_drained", exp4_q.size(), 0);
    repeat (3) @(posedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
